// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the fabric reset sequencer.
// Counter widths are sized from the lock-qualification and release-gap lengths.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        STABILIZE,
        RELEASE,
        RUN,
        DRAIN
    } state_t;

    localparam int LOCK_STABLE_CYCLES_DEF = 16;
    localparam int RELEASE_GAP_DEF        = 8;

    localparam logic [7:0] LOST_CNT_MAX = 8'd255;

    // One counter serves both lock qualification and the release/drain gap.
    function automatic int cnt_width(input int lock_cycles, input int gap);
        int w;
        w = $clog2((lock_cycles > gap) ? lock_cycles : gap);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared synchronously.
// Latency: 2 cycles. No backpressure.
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Qualifies PLL lock, then releases reset domains in order and re-asserts them in reverse.
// Latency: lock to first release LOCK_STABLE_CYCLES+2 edges. No backpressure; SW request is a level.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS        = 4,
    parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
    parameter int RELEASE_GAP        = RELEASE_GAP_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   pll_lock,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] domain_resetn,
    output logic                   sys_ready,
    output logic                   sw_rst_ack,
    output logic [7:0]             lock_lost_cnt
);

    localparam int CW = cnt_width(LOCK_STABLE_CYCLES, RELEASE_GAP);
    localparam int IW = $clog2(NUM_DOMAINS + 1);

    localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(RELEASE_GAP - 1);
    localparam logic [IW-1:0] IDX_DRAIN = (NUM_DOMAINS >= 2) ? IW'(NUM_DOMAINS - 2) : '0;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          lock_s;

    sync_2ff u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_lock),
        .q      (lock_s)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= HOLD;
            domain_resetn <= '0;
            sys_ready     <= 1'b0;
            sw_rst_ack    <= 1'b0;
            lock_lost_cnt <= 8'd0;
            cnt           <= '0;
            idx           <= '0;
        end else begin
            sw_rst_ack <= 1'b0;
            // Lock loss once any domain may be out of reset slams everything back, ahead of SW requests.
            if (!lock_s && (state inside {RELEASE, RUN, DRAIN})) begin
                state         <= HOLD;
                domain_resetn <= '0;
                sys_ready     <= 1'b0;
                if (lock_lost_cnt != LOST_CNT_MAX) begin
                    lock_lost_cnt <= lock_lost_cnt + 8'd1;
                end
            end else begin
                case (state)
                    HOLD: begin
                        if (lock_s && !sw_rst_req) begin
                            state <= STABILIZE;
                            cnt   <= '0;
                        end
                    end
                    STABILIZE: begin
                        if (!lock_s) begin
                            state <= HOLD;
                        end else if (cnt == STAB_LAST) begin
                            state            <= RELEASE;
                            domain_resetn[0] <= 1'b1;
                            idx              <= IW'(1);
                            cnt              <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (domain_resetn[NUM_DOMAINS-1]) begin
                            state     <= RUN;
                            sys_ready <= 1'b1;
                        end else if (cnt == GAP_LAST) begin
                            for (int k = 0; k < NUM_DOMAINS; k++) begin
                                if (idx == IW'(k)) domain_resetn[k] <= 1'b1;
                            end
                            idx <= idx + 1'b1;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (sw_rst_req) begin
                            state                        <= DRAIN;
                            domain_resetn[NUM_DOMAINS-1] <= 1'b0;
                            sys_ready                    <= 1'b0;
                            idx                          <= IDX_DRAIN;
                            cnt                          <= '0;
                        end
                    end
                    DRAIN: begin
                        if (!domain_resetn[0]) begin
                            state      <= HOLD;
                            sw_rst_ack <= 1'b1;
                        end else if (cnt == GAP_LAST) begin
                            for (int k = 0; k < NUM_DOMAINS; k++) begin
                                if (idx == IW'(k)) domain_resetn[k] <= 1'b0;
                            end
                            idx <= idx - 1'b1;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= HOLD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized and directed bench for reset_sequencer against an edge-timestamp reference model.
module tb_reset_sequencer;

    localparam int N    = 4;
    localparam int LSC  = 16;
    localparam int G    = 8;
    localparam int SPAN = (N - 1) * G + 1;

    localparam int M_HOLD = 0, M_STAB = 1, M_REL = 2, M_RUN = 3, M_DRAIN = 4;

    logic         clk = 1'b0;
    logic         resetn, pll_lock, sw_rst_req;
    logic [N-1:0] domain_resetn;
    logic         sys_ready, sw_rst_ack;
    logic [7:0]   lock_lost_cnt;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS        (N),
        .LOCK_STABLE_CYCLES (LSC),
        .RELEASE_GAP        (G)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pll_lock      (pll_lock),
        .sw_rst_req    (sw_rst_req),
        .domain_resetn (domain_resetn),
        .sys_ready     (sys_ready),
        .sw_rst_ack    (sw_rst_ack),
        .lock_lost_cnt (lock_lost_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int e       = 0;

    // Reference model: mode plus the edge at which it was entered.
    int m_mode = M_HOLD;
    int m_t0   = 0;
    int m_lost = 0;
    bit m_ack  = 1'b0;
    bit p1     = 1'b0;
    bit p2     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    function automatic int n_released();
        int r;
        case (m_mode)
            M_REL:   begin r = 1 + (e - m_t0) / G; if (r > N) r = N; end
            M_RUN:   r = N;
            M_DRAIN: begin r = N - 1 - (e - m_t0) / G; if (r < 0) r = 0; end
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic model_edge(input bit rn, input bit pll, input bit req);
        bit ls;
        m_ack = 1'b0;
        if (!rn) begin
            m_mode = M_HOLD;
            m_lost = 0;
            p1     = 1'b0;
            p2     = 1'b0;
        end else begin
            ls = p2;
            if (!ls && (m_mode == M_REL || m_mode == M_RUN || m_mode == M_DRAIN)) begin
                m_mode = M_HOLD;
                if (m_lost < 255) m_lost++;
            end else begin
                case (m_mode)
                    M_HOLD:  if (ls && !req) begin m_mode = M_STAB; m_t0 = e; end
                    M_STAB:  if (!ls) m_mode = M_HOLD;
                             else if (e - m_t0 == LSC) begin m_mode = M_REL; m_t0 = e; end
                    M_REL:   if (e - m_t0 == SPAN) m_mode = M_RUN;
                    M_RUN:   if (req) begin m_mode = M_DRAIN; m_t0 = e; end
                    M_DRAIN: if (e - m_t0 == SPAN) begin m_mode = M_HOLD; m_ack = 1'b1; end
                    default: m_mode = M_HOLD;
                endcase
            end
            p2 = p1;
            p1 = pll;
        end
    endtask

    task automatic step(input bit rn, input bit pll, input bit req);
        logic [31:0] d;
        resetn     = rn;
        pll_lock   = pll;
        sw_rst_req = req;
        @(posedge clk);
        model_edge(rn, pll, req);
        #1;
        d = 32'(domain_resetn);
        check_eq("domain_resetn", d, (32'd1 << n_released()) - 32'd1);
        check_eq("sys_ready", 32'(sys_ready), 32'(m_mode == M_RUN));
        check_eq("sw_rst_ack", 32'(sw_rst_ack), 32'(m_ack));
        check_eq("lock_lost_cnt", 32'(lock_lost_cnt), 32'(m_lost));
        check_eq("thermometer", 32'(((d + 32'd1) & d) == 32'd0), 32'd1);
        e++;
    endtask

    task automatic run_to_ready(input int budget);
        for (int i = 0; i < budget && !sys_ready; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("reach_run", 32'(sys_ready), 32'd1);
    endtask

    initial begin
        int first;
        resetn = 1'b0; pll_lock = 1'b0; sw_rst_req = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        // Clean power-up: first release at edge 18, ready at 43.
        first = -1;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i == 18) check_eq("dom_at_18", 32'(domain_resetn), 32'h1);
            if (i == 26) check_eq("dom_at_26", 32'(domain_resetn), 32'h3);
            if (i == 34) check_eq("dom_at_34", 32'(domain_resetn), 32'h7);
            if (i == 42) check_eq("dom_at_42", 32'(domain_resetn), 32'hF);
            if (first < 0 && sys_ready) first = i;
        end
        check_eq("ready_edge", 32'(first), 32'd43);

        // Software re-reset: ACK after SPAN edges, no restart while request is held.
        first = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (first < 0 && sw_rst_ack) first = i;
        end
        check_eq("drain_len", 32'(first), 32'(SPAN));
        check_eq("held_in_hold", 32'(domain_resetn), 32'h0);
        run_to_ready(80);

        // One-cycle lock glitch during STABILIZE restarts the full qualification.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        first = -1;
        for (int i = 0; i < 45; i++) begin
            step(1'b1, (i != 12), 1'b0);
            if (first < 0 && domain_resetn[0]) first = i;
        end
        check_eq("glitch_release_edge", 32'(first), 32'd31);
        check_eq("glitch_no_loss", 32'(lock_lost_cnt), 32'd0);
        run_to_ready(80);

        // Lock loss in RELEASE, then in RUN.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 28; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("in_release_0011", 32'(domain_resetn), 32'h3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("loss_release_cnt", 32'(lock_lost_cnt), 32'd1);
        run_to_ready(80);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("loss_run_cnt", 32'(lock_lost_cnt), 32'd2);

        // Lock loss coincides with a SW request in RUN.
        run_to_ready(80);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_eq("loss_beats_req", 32'(domain_resetn), 32'h0);
        check_eq("loss_req_cnt", 32'(lock_lost_cnt), 32'd3);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1);

        // Saturation after 300 forced losses.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("loss_saturate", 32'(lock_lost_cnt), 32'd255);

        // RESETN mid-DRAIN, then a clean sequence.
        run_to_ready(80);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_eq("reset_mid_drain_dom", 32'(domain_resetn), 32'h0);
        check_eq("reset_mid_drain_cnt", 32'(lock_lost_cnt), 32'd0);
        run_to_ready(80);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit rn, pll, req;
            rn  = ($urandom_range(0, 199) != 0);
            pll = ($urandom_range(0, 99) >= 2);
            req = ($urandom_range(0, 29) == 0) ? ~sw_rst_req : sw_rst_req;
            step(rn, pll, req);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Synchronous reset sequencer for the MiV fabric clock domain. It qualifies the clock source's lock indication. It then releases up to eight downstream reset domains in a fixed, staggered order so that the interconnect, the core and the peripherals leave reset cleanly. It also handles lock loss and software-requested re-reset. It sits directly downstream of the clock generator/PLL and drives the RESETN inputs of every fabric subsystem.

## Interface
- NUM_DOMAINS, 4, number of reset domains, 1..8; domain 0 is released first.
- LOCK_STABLE_CYCLES, 16, consecutive synchronized-lock cycles required before release, ≥1.
- RELEASE_GAP, 8, cycles between successive domain release/assert steps, ≥1.
- CLK  in  1  fabric clock; all logic on the rising edge.
- RESETN  in  1  synchronous, active-low reset.
- PLL_LOCK  in  1  asynchronous lock indication; synchronized internally through two flops.
- SW_RST_REQ  in  1  level request for an ordered re-reset; synchronous to CLK.
- DOMAIN_RESETN  out  NUM_DOMAINS  per-domain active-low reset, registered.
- SYS_READY  out  1  high only in RUN.
- SW_RST_ACK  out  1  one-cycle pulse when a software re-reset completes.
- LOCK_LOST_CNT  out  8  saturating count of lock losses after release began.

## Operation
- **Reset (RESETN=0):**
  - State = HOLD.
  - DOMAIN_RESETN = all 0, SYS_READY = 0, SW_RST_ACK = 0, LOCK_LOST_CNT = 0.
  - Sync flops = 0; all counters = 0.
- **lock_s** is the second synchronizer flop.
- **HOLD:** go to STABILIZE with cnt=0 when lock_s=1 and SW_RST_REQ=0.
- **STABILIZE:**
  - If lock_s=0, go to HOLD; no count increment.
  - Else if cnt == LOCK_STABLE_CYCLES-1, go to RELEASE, set DOMAIN_RESETN[0]=1, idx=1, gap=0.
  - Else cnt++.
- **RELEASE:**
  - gap counts 0..RELEASE_GAP-1.
  - At gap == RELEASE_GAP-1: set DOMAIN_RESETN[idx]=1, idx++, gap=0.
  - The edge after the last domain is released (or the edge after entry when NUM_DOMAINS=1): go to RUN, SYS_READY=1.
- **RUN:** SW_RST_REQ=1 moves to DRAIN. On that edge: DOMAIN_RESETN[NUM_DOMAINS-1]=0, SYS_READY=0, idx=NUM_DOMAINS-2, gap=0.
- **DRAIN:**
  - Domains are re-asserted in reverse order, one every RELEASE_GAP cycles.
  - The edge after domain 0 is asserted: go to HOLD and pulse SW_RST_ACK=1 for exactly one cycle.
  - HOLD then waits for SW_RST_REQ=0 before restarting.
- **Lock loss (lock_s=0) in RELEASE, RUN or DRAIN:**
  - On the next edge: all DOMAIN_RESETN=0, SYS_READY=0, go to HOLD.
  - LOCK_LOST_CNT increments, saturating at 255.
  - No SW_RST_ACK is issued.
- **Priority:** lock loss beats SW_RST_REQ on the same edge. SW_RST_REQ outside RUN is ignored (no ACK) until the next RUN.
- **Invariant:** DOMAIN_RESETN is always thermometer-shaped. Domain k is never released while any domain j<k is in reset.

## Timing
- Edge 0 is the first edge that samples PLL_LOCK=1 with RESETN high and SW_RST_REQ=0.
- lock_s=1 after edge 1; STABILIZE is entered at edge 2.
- DOMAIN_RESETN[k] rises at edge LOCK_STABLE_CYCLES + 2 + k·RELEASE_GAP.
- SYS_READY rises at edge LOCK_STABLE_CYCLES + 2 + (NUM_DOMAINS-1)·RELEASE_GAP + 1.
- PLL_LOCK falling to all resets asserted takes 3 edges (2 sync + 1 register).
- DRAIN total, from the SW_RST_REQ-sampled edge to SW_RST_ACK: (NUM_DOMAINS-1)·RELEASE_GAP + 1 edges.
- RESETN asserted mid-sequence overrides everything at the same edge.

## Structure
- Package rst_seq_pkg holds:
  - state enum {HOLD, STABILIZE, RELEASE, RUN, DRAIN};
  - counter width constants derived by $clog2 from LOCK_STABLE_CYCLES and RELEASE_GAP;
  - the LOCK_LOST_CNT saturation constant (255).
- Sub-module sync_2ff: a two-flop synchronizer, synchronously cleared by RESETN. Used for PLL_LOCK.
- Top: one FSM, one shared cnt/gap counter, one idx register, one saturating counter.

## Test plan
- Defaults, PLL_LOCK high from reset release → DOMAIN_RESETN steps 0001 at edge 18, 0011 at 26, 0111 at 34, 1111 at 42. SYS_READY=1 at 43.
- PLL_LOCK pulses low for 1 cycle during STABILIZE (cnt=10) → returns to HOLD. The full 16-cycle count restarts. LOCK_LOST_CNT stays 0.
- SW_RST_REQ held high in RUN → DOMAIN_RESETN goes 0111, 0011, 0001, 0000 at 8-cycle spacing. SW_RST_ACK pulses once, 1 cycle after 0000. The sequence restarts only after SW_RST_REQ drops.
- PLL_LOCK low during RELEASE (0011) → all resets 0 three edges later, LOCK_LOST_CNT=1, no ACK. The same in RUN gives LOCK_LOST_CNT=2.
- Lock loss and SW_RST_REQ on the same RUN cycle → immediate full assert, counter increments, no ACK. 300 forced losses → LOCK_LOST_CNT saturates at 255.
- RESETN pulsed low mid-DRAIN → all outputs at their reset values on that edge. A clean full sequence follows.
